// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared types and helpers for the FIFO write-port arbiter (fifo_wr_arbiter)
//   and its round-robin picker (rr_pick).
//   - arb_state_e : arbiter FSM state encoding
//   - id_width()  : index width for a given requester count (at least 1 bit)
//   - rr_next()   : wrapped candidate index without a modulo operator, so a
//                   requester count that is not a power of two wraps correctly
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index found 'offset' places after 'ptr' (offset in 1..n, ptr < n).
  // ptr + offset never reaches 2n, so a single conditional subtract wraps it.
  function automatic int rr_next(input int ptr, input int offset, input int n);
    int sum;
    sum = ptr + offset;
    return (sum >= n) ? sum - n : sum;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Scans valid_i starting one place after
//   ptr_i (ptr_i itself is visited last) and returns the first set index.
// Ports
//   valid_i  [NUM_REQ]   request vector
//   ptr_i    [ID_WIDTH]  index of the most recent winner
//   onehot_o [NUM_REQ]   one-hot winner, zero when nothing is valid
//   id_o     [ID_WIDTH]  binary winner index, zero when nothing is valid
//   any_o                at least one request valid
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  valid_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  onehot_o,
  output logic [ID_WIDTH-1:0] id_o,
  output logic                any_o
);

  // Nested loop keeps every vector index constant; the match is found by
  // comparing each requester index against the wrapped candidate position.
  always_comb begin
    onehot_o = '0;
    id_o     = '0;
    any_o    = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any_o && valid_i[j] && (rr_next(int'(ptr_i), off, NUM_REQ) == j)) begin
          any_o       = 1'b1;
          onehot_o[j] = 1'b1;
          id_o        = ID_WIDTH'(j);
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin, burst-locked arbiter sharing one FIFO write port among
//   NUM_REQ requesters. A grant is held from the first beat until the beat
//   flagged last is accepted, so bursts never interleave. While locked, data,
//   valid and ready pass straight through combinationally (no data register).
//   Optional build macro FIFO_WR_ARB_WATERMARK_EN: withholds new grants while
//   fifo_counter_i >= WM_LEVEL; a burst already locked is never interrupted.
//   Without the macro fifo_counter_i is ignored.
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   req_data_i        packed payloads, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_valid_i       per-requester valid
//   req_last_i        per-requester last-beat flag, qualified by valid
//   req_ready_o       per-requester ready, at most one bit set
//   fifo_data_o       payload to FIFO
//   fifo_wr_valid_o   write valid to FIFO
//   fifo_wr_ready_i   write ready from FIFO
//   fifo_counter_i    FIFO occupancy
//   grant_o           registered one-hot grant
//   grant_id_o        registered binary grant index (held after the burst)
//   busy_o            high while a burst owns the write port
//
//   state    | meaning
//   ARB_IDLE | no owner; arbitrate among valid requesters (one cycle)
//   ARB_LOCK | grant_id_q owns the write port until its last beat handshakes
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int ID_WIDTH   = id_width(NUM_REQ),
  parameter int WM_LEVEL   = FIFO_DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic                          fifo_wr_valid_o,
  input  logic                          fifo_wr_ready_i,
  input  logic [ADDR_WIDTH:0]           fifo_counter_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [ID_WIDTH-1:0]           grant_id_o,
  output logic                          busy_o
);

  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [ID_WIDTH-1:0] pick_id;
  logic                pick_any;
  logic                grant_ok;
  logic                lock;
  logic                hs;

  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_data_arr[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef FIFO_WR_ARB_WATERMARK_EN
  assign grant_ok = (fifo_counter_i < (ADDR_WIDTH+1)'(WM_LEVEL));
`else
  logic unused_wm;
  assign grant_ok  = 1'b1;
  assign unused_wm = (^fifo_counter_i) ^ (WM_LEVEL > 0);
`endif

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .valid_i  (req_valid_i),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .id_o     (pick_id),
    .any_o    (pick_any)
  );

  assign lock = (state_q == ARB_LOCK);
  assign hs   = lock & req_valid_i[grant_id_q] & fifo_wr_ready_i;

  // Write-port pass-through; in IDLE the data mux still follows grant_id_q
  // but valid is low, so the payload is a don't-care.
  assign fifo_data_o     = req_data_arr[grant_id_q];
  assign fifo_wr_valid_o = lock & req_valid_i[grant_id_q];

  always_comb begin
    req_ready_o = '0;
    if (lock) begin
      req_ready_o[grant_id_q] = fifo_wr_ready_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any && grant_ok) begin
          state_d    = ARB_LOCK;
          grant_d    = pick_onehot;
          grant_id_d = pick_id;
        end
      end
      ARB_LOCK: begin
        // Pointer only moves when a burst completes, so a stalled or
        // paused owner keeps the port indefinitely.
        if (hs && req_last_i[grant_id_q]) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = grant_id_q;
          grant_d  = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= ID_WIDTH'(NUM_REQ - 1);
      grant_q    <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign grant_o    = grant_q;
  assign grant_id_o = grant_id_q;
  assign busy_o     = lock;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed scenarios followed by randomized traffic, checked every cycle
//   against a transaction-level model of the arbiter (owner / last winner).
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 32;
  localparam int FIFO_DEPTH = 32;
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int ID_WIDTH   = $clog2(NUM_REQ);
  localparam int WM_LEVEL   = FIFO_DEPTH - 2;

  logic                          clk;
  logic                          rst_n;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_last_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [DATA_WIDTH-1:0]         fifo_data_o;
  logic                          fifo_wr_valid_o;
  logic                          fifo_wr_ready_i;
  logic [ADDR_WIDTH:0]           fifo_counter_i;
  logic [NUM_REQ-1:0]            grant_o;
  logic [ID_WIDTH-1:0]           grant_id_o;
  logic                          busy_o;

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ID_WIDTH   (ID_WIDTH),
    .WM_LEVEL   (WM_LEVEL)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_data_i      (req_data_i),
    .req_valid_i     (req_valid_i),
    .req_last_i      (req_last_i),
    .req_ready_o     (req_ready_o),
    .fifo_data_o     (fifo_data_o),
    .fifo_wr_valid_o (fifo_wr_valid_o),
    .fifo_wr_ready_i (fifo_wr_ready_i),
    .fifo_counter_i  (fifo_counter_i),
    .grant_o         (grant_o),
    .grant_id_o      (grant_id_o),
    .busy_o          (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: is a burst in progress, who owns it / owned the last one, and
  // who completed the most recent burst.
  bit m_lock;
  int m_gid;
  int m_last;

  logic [NUM_REQ-1:0] hs;
  int rem [NUM_REQ];
  int seq [NUM_REQ];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = 1'b0;
    m_gid  = 0;
    m_last = NUM_REQ - 1;
  endtask

  function automatic bit wm_allows();
`ifdef FIFO_WR_ARB_WATERMARK_EN
    return fifo_counter_i < WM_LEVEL;
`else
    return 1'b1;
`endif
  endfunction

  task automatic set_data(input int k, input logic [DATA_WIDTH-1:0] d);
    req_data_i[k*DATA_WIDTH +: DATA_WIDTH] = d;
  endtask

  // Compare every output at the falling edge against the model.
  task automatic sample();
    logic [NUM_REQ-1:0]    exp_grant;
    logic [NUM_REQ-1:0]    exp_ready;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  exp_wv;
    @(negedge clk);
    exp_grant = m_lock ? (NUM_REQ'(1) << m_gid) : '0;
    exp_ready = (m_lock && fifo_wr_ready_i) ? exp_grant : '0;
    exp_wv    = m_lock && req_valid_i[m_gid];
    exp_data  = req_data_i[m_gid*DATA_WIDTH +: DATA_WIDTH];
    chk("grant", grant_o, exp_grant);
    chk("grant_id", grant_id_o, m_gid);
    chk("busy", busy_o, m_lock);
    chk("wr_valid", fifo_wr_valid_o, exp_wv);
    chk("ready", req_ready_o, exp_ready);
    chk("data", fifo_data_o, exp_data);
    hs = '0;
    if (m_lock && req_valid_i[m_gid] && fifo_wr_ready_i) hs[m_gid] = 1'b1;
  endtask

  // Advance the model across the rising edge using the stable inputs.
  task automatic advance();
    @(posedge clk);
    if (rst_n) begin
      if (m_lock) begin
        if (req_valid_i[m_gid] && fifo_wr_ready_i && req_last_i[m_gid]) begin
          m_lock = 1'b0;
          m_last = m_gid;
        end
      end else if (wm_allows()) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int c;
          c = (m_last + k) % NUM_REQ;
          if (req_valid_i[c]) begin
            m_gid  = c;
            m_lock = 1'b1;
            break;
          end
        end
      end
    end
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    req_valid_i     = '0;
    req_last_i      = '0;
    req_data_i      = '0;
    fifo_wr_ready_i = 1'b1;
    fifo_counter_i  = '0;
    hs              = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rem[k] = 0;
      seq[k] = 0;
    end
    model_reset();

    // Reset values
    @(posedge clk);
    sample();
    chk("rst_grant", grant_o, 0);
    chk("rst_gid", grant_id_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", req_ready_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: all single-beat -> 0,1,2,3,0 with an idle cycle between
    req_valid_i = '1;
    req_last_i  = '1;
    for (int k = 0; k < NUM_REQ; k++) set_data(k, DATA_WIDTH'(32'h1000 + k));
    for (int i = 0; i < 10; i++) begin
      sample();
      chk("t1_busy", busy_o, i % 2);
      if (i % 2 == 1) chk("t1_gid", grant_id_o, ((i - 1) / 2) % NUM_REQ);
      advance();
    end
    req_valid_i = '0;
    req_last_i  = '0;

    // 2: req2 4-beat burst, req1 joins at beat 1 and must wait
    for (int b = 0; b < 4; b++) begin
      set_data(2, DATA_WIDTH'(32'h2000 + b));
      req_valid_i[2] = 1'b1;
      req_last_i[2]  = (b == 3);
      if (b >= 1) begin
        req_valid_i[1] = 1'b1;
        req_last_i[1]  = 1'b1;
        set_data(1, 32'h2100);
      end
      if (b == 0) begin
        sample();
        chk("t2_idle", busy_o, 0);
        advance();
      end
      sample();
      chk("t2_ready", req_ready_o, 4'b0100);
      chk("t2_data", fifo_data_o, 32'h2000 + b);
      advance();
    end
    req_valid_i[2] = 1'b0;
    req_last_i[2]  = 1'b0;
    sample();
    chk("t2_gap", busy_o, 0);
    advance();
    sample();
    chk("t2_next_gid", grant_id_o, 1);
    chk("t2_next_ready", req_ready_o, 4'b0010);
    advance();
    req_valid_i = '0;
    req_last_i  = '0;

    // 3: FIFO full for 5 cycles mid-burst of req3
    req_valid_i[3] = 1'b1;
    set_data(3, 32'h3000);
    sample();
    advance();
    sample();
    chk("t3_b0", fifo_data_o, 32'h3000);
    advance();
    set_data(3, 32'h3001);
    fifo_wr_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("t3_hold_valid", fifo_wr_valid_o, 1);
      chk("t3_hold_ready", req_ready_o, 0);
      chk("t3_hold_data", fifo_data_o, 32'h3001);
      advance();
    end
    fifo_wr_ready_i = 1'b1;
    sample();
    chk("t3_b1", fifo_data_o, 32'h3001);
    chk("t3_b1_ready", req_ready_o, 4'b1000);
    advance();
    set_data(3, 32'h3002);
    req_last_i[3] = 1'b1;
    sample();
    chk("t3_b2", fifo_data_o, 32'h3002);
    advance();
    req_valid_i = '0;
    req_last_i  = '0;
    sample();
    chk("t3_done", busy_o, 0);
    advance();

    // 4: owner req0 pauses valid for 3 cycles while others wait
    req_valid_i = 4'b1111;
    req_last_i  = 4'b1110;
    set_data(0, 32'h4000);
    sample();
    advance();
    sample();
    chk("t4_gid", grant_id_o, 0);
    advance();
    req_valid_i[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t4_busy", busy_o, 1);
      chk("t4_gid_hold", grant_id_o, 0);
      chk("t4_wv", fifo_wr_valid_o, 0);
      advance();
    end
    req_valid_i[0] = 1'b1;
    req_last_i[0]  = 1'b1;
    set_data(0, 32'h4001);
    sample();
    chk("t4_resume_wv", fifo_wr_valid_o, 1);
    chk("t4_resume_data", fifo_data_o, 32'h4001);
    advance();

    // 5: asynchronous reset while req1 holds the lock
    req_last_i = '0;
    sample();
    advance();
    sample();
    chk("t5_pre_busy", busy_o, 1);
    chk("t5_pre_gid", grant_id_o, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_grant", grant_o, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_wv", fifo_wr_valid_o, 0);
    chk("t5_ready", req_ready_o, 0);
    chk("t5_gid", grant_id_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    req_valid_i = '1;
    req_last_i  = '1;
    sample();
    advance();
    sample();
    chk("t5_first_gid", grant_id_o, 0);
    advance();
    req_valid_i = '0;
    req_last_i  = '0;
    sample();
    advance();

`ifdef FIFO_WR_ARB_WATERMARK_EN
    // 6: watermark blocks new grants only
    fifo_counter_i = 30;
    req_valid_i[1] = 1'b1;
    set_data(1, 32'h6000);
    sample();
    advance();
    sample();
    chk("t6_wm_block", busy_o, 0);
    advance();
    fifo_counter_i = 29;
    sample();
    chk("t6_wm_still_idle", busy_o, 0);
    advance();
    sample();
    chk("t6_wm_grant", busy_o, 1);
    chk("t6_wm_gid", grant_id_o, 1);
    advance();
    fifo_counter_i = 31;
    req_last_i[1]  = 1'b1;
    set_data(1, 32'h6001);
    sample();
    chk("t6_lock_kept", busy_o, 1);
    chk("t6_lock_wv", fifo_wr_valid_o, 1);
    advance();
    req_valid_i    = '0;
    req_last_i     = '0;
    fifo_counter_i = '0;
    sample();
    advance();
`endif

    // Randomized traffic: beats held until accepted, random pauses/stalls
    for (int cyc = 0; cyc < 4000; cyc++) begin
      sample();
      advance();
      for (int k = 0; k < NUM_REQ; k++) begin
        if (hs[k]) begin
          seq[k]++;
          rem[k]--;
          req_valid_i[k] = 1'b0;
        end
        if (!req_valid_i[k]) begin
          if (rem[k] == 0 && $urandom_range(0, 3) == 0) rem[k] = $urandom_range(1, 5);
          if (rem[k] > 0 && $urandom_range(0, 3) != 0) begin
            req_valid_i[k] = 1'b1;
            req_last_i[k]  = (rem[k] == 1);
            set_data(k, DATA_WIDTH'({8'(k), 24'(seq[k])}));
          end else begin
            req_last_i[k] = 1'($urandom_range(0, 1));
          end
        end
      end
      fifo_wr_ready_i = ($urandom_range(0, 9) < 8);
      fifo_counter_i  = (ADDR_WIDTH+1)'($urandom_range(0, FIFO_DEPTH));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
